dot_product_accumulator: RTL and testbench

Streaming signed multiply-accumulate stage that computes the dot product of two operand vectors delivered one element pair per beat. It sits directly upstream of the accelerator's result registers. Its result/result_valid pair drives a downstream register's d/enable path through a valid/ready handshake. A new vector is launched by a start pulse carrying the element count.

---
 rtl/dot_product_accumulator_pkg.sv | 23 ++
 rtl/dot_product_accumulator_signed_multiplier.sv | 17 +
 rtl/dot_product_accumulator.sv | 136 +++++++++++++
 tb/tb_dot_product_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator.
// Contents:
//   - FSM state encoding.
//   - Default width constants.
//   - Width-legality helper used by the top-level elaboration check.
package dot_product_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_COUNT_WIDTH = 8;

  // The accumulator must hold at least one full-precision product.
  function automatic bit acc_width_ok(input int data_width, input int acc_width);
    return acc_width >= 2 * data_width;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_signed_multiplier.sv
// Combinational signed multiplier.
// Kept in its own module so that synthesis can map it onto a DSP slice.
// It can also be pipelined later without touching the accumulator FSM.
// Ports:
//   a, b    : signed DATA_WIDTH operands
//   product : full-precision signed product (2*DATA_WIDTH)
module signed_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic signed [2*DATA_WIDTH-1:0] product
);

  assign product = a * b;

endmodule

// File: rtl/dot_product_accumulator.sv
// Streaming signed multiply-accumulate.
// Computes the dot product of two vectors delivered one element pair per beat.
// Ports:
//   clk, reset          : clock (posedge); asynchronous active-low reset
//   start, length       : launch pulse and element count (sampled in IDLE only)
//   a_data, b_data      : signed operand pair
//   in_valid / in_ready : operand handshake (ready only while accumulating)
//   result              : signed dot product
//   result_valid / result_ready : result handshake
//   busy                : high whenever the FSM is not idle
//   overflow            : sticky wrap flag for the current vector
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0]  a_data,
  input  logic [DATA_WIDTH-1:0]  b_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   busy,
  output logic                   overflow
);

  if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("dot_product_accumulator: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic                   overflow_q, overflow_d;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic [ACC_WIDTH-1:0]           sum;
  logic                           add_overflow;

  signed_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .a       (a_data),
    .b       (b_data),
    .product (product)
  );

  // Size cast of a signed value sign-extends to the accumulator width.
  assign product_ext = ACC_WIDTH'(product);
  assign sum         = acc_q + product_ext;

  // Signed overflow: both addends share a sign and the sum's sign differs.
  assign add_overflow = (acc_q[ACC_WIDTH-1] == product_ext[ACC_WIDTH-1]) &&
                        (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = length;
          acc_d       = '0;
          overflow_d  = 1'b0;
          if (length == '0) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        // in_ready is constantly high here, so in_valid alone marks a beat.
        if (in_valid) begin
          acc_d       = sum;
          remaining_d = remaining_q - COUNT_WIDTH'(1);
          if (add_overflow) begin
            overflow_d = 1'b1;
          end
          if (remaining_q == COUNT_WIDTH'(1)) begin
            result_d = sum;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start arriving with the handshake is deliberately dropped.
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready     = (state_q == ST_ACCUM);
    result_valid = (state_q == ST_DONE);
    busy         = (state_q != ST_IDLE);
    result       = result_q;
    overflow     = overflow_q;
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  length;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        overflow;

  dot_product_accumulator #(
    .DATA_WIDTH(16),
    .ACC_WIDTH(32),
    .COUNT_WIDTH(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .a_data       (a_data),
    .b_data       (b_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [15:0] a[4];
    logic [15:0] b[4];
    logic [3:0]  gap;   // bit i: drop in_valid for two cycles before beat i
    int          hold;  // cycles result_ready stays low in DONE
    logic [31:0] exp_result;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } sb_t;

  vec_t vecs[7];
  sb_t  sb[$];
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at the sample point where result_valid && result_ready.
  task automatic sb_check();
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow actual=result_%0h expected=no_result", result);
    end else begin
      e = sb.pop_front();
      check("sb_result", result, e.res);
      check("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
      $display("txn result=%0h overflow=%0b", result, overflow);
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    start    = 1'b1;
    length   = v.len;
    in_valid = 1'b1;          // must be ignored while idle
    a_data   = 16'h7fff;
    b_data   = 16'h7fff;
    e.res = v.exp_result;
    e.ovf = v.exp_ovf;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.gap[i]) begin
        in_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("stall_ready", {31'd0, in_ready}, 32'd1);
        end
      end
      check("beat_ready", {31'd0, in_ready}, 32'd1);
      check("beat_busy", {31'd0, busy}, 32'd1);
      in_valid = 1'b1;
      a_data   = v.a[i];
      b_data   = v.b[i];
      @(negedge clk);
    end
    // Keep offering garbage to prove DONE consumes nothing.
    in_valid = 1'b1;
    a_data   = 16'd1;
    b_data   = 16'd1;
    check("latency_valid", {31'd0, result_valid}, 32'd1);
    check("done_ready", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, result_valid}, 32'd1);
      check("hold_result", result, v.exp_result);
    end
    result_ready = 1'b1;
    if (result_valid) sb_check();
    @(negedge clk);
    result_ready = 1'b0;
    in_valid     = 1'b0;
    check("post_hs_valid", {31'd0, result_valid}, 32'd0);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
    check("post_hs_result", result, v.exp_result);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{len:8'd3, a:'{16'd2, -16'sd4, 16'd7, 16'd0}, b:'{16'd3, 16'd5, -16'sd1, 16'd0},
                gap:4'b0000, hold:0, exp_result:32'hFFFF_FFEB, exp_ovf:1'b0};  // -21
    vecs[1] = '{len:8'd0, a:'{16'd0, 16'd0, 16'd0, 16'd0}, b:'{16'd0, 16'd0, 16'd0, 16'd0},
                gap:4'b0000, hold:1, exp_result:32'd0, exp_ovf:1'b0};
    vecs[2] = '{len:8'd2, a:'{16'd100, -16'sd50, 16'd0, 16'd0}, b:'{16'd100, 16'd2, 16'd0, 16'd0},
                gap:4'b0010, hold:5, exp_result:32'd9900, exp_ovf:1'b0};
    // Three products of 2^30: wraps on the second add, ends at 0xC0000000.
    vecs[3] = '{len:8'd3, a:'{16'h8000, 16'h8000, 16'h8000, 16'd0}, b:'{16'h8000, 16'h8000, 16'h8000, 16'd0},
                gap:4'b0000, hold:2, exp_result:32'hC000_0000, exp_ovf:1'b1};
    // -32768*32767; also shows the new start cleared the sticky flag.
    vecs[4] = '{len:8'd1, a:'{16'h8000, 16'd0, 16'd0, 16'd0}, b:'{16'h7fff, 16'd0, 16'd0, 16'd0},
                gap:4'b0000, hold:0, exp_result:32'hC000_8000, exp_ovf:1'b0};
    // 4 * 0x3FFF0001: overflow on the third add, sticky through the fourth.
    vecs[5] = '{len:8'd4, a:'{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff}, b:'{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff},
                gap:4'b0101, hold:1, exp_result:32'hFFFC_0004, exp_ovf:1'b1};
    vecs[6] = '{len:8'd1, a:'{16'd3, 16'd0, 16'd0, 16'd0}, b:'{16'd3, 16'd0, 16'd0, 16'd0},
                gap:4'b0000, hold:0, exp_result:32'd9, exp_ovf:1'b0};

    reset = 1'b0; start = 1'b0; length = '0; a_data = '0; b_data = '0;
    in_valid = 1'b0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start ignored during ACCUM and during the DONE handshake: (5*6)+(-2*3)=24.
    begin
      sb_t e;
      @(negedge clk);
      start = 1'b1; length = 8'd2;
      e.res = 32'd24; e.ovf = 1'b0; sb.push_back(e);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; a_data = 16'd5; b_data = 16'd6;
      @(negedge clk);
      in_valid = 1'b0; start = 1'b1; length = 8'd1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", {31'd0, busy}, 32'd1);
      check("ign_ready", {31'd0, in_ready}, 32'd1);
      check("ign_valid", {31'd0, result_valid}, 32'd0);
      in_valid = 1'b1; a_data = -16'sd2; b_data = 16'd3;
      @(negedge clk);
      in_valid = 1'b0;
      check("ign_done_valid", {31'd0, result_valid}, 32'd1);
      start = 1'b1; length = 8'd3; result_ready = 1'b1;
      sb_check();
      @(negedge clk);
      start = 1'b0; result_ready = 1'b0;
      check("ign_hs_busy", {31'd0, busy}, 32'd0);
      check("ign_hs_valid", {31'd0, result_valid}, 32'd0);
      @(negedge clk);
      check("ign_not_queued", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset mid-vector after the sticky flag is set.
    @(negedge clk);
    start = 1'b1; length = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_data = 16'h7fff; b_data = 16'h7fff;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_overflow", {31'd0, overflow}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_valid", {31'd0, result_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_overflow", {31'd0, overflow}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[6]);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
